game_timer: RTL
===============

Name: game_timer

Overview:
- Countdown game clock (MM:SS, BCD) for the basketball scoreboard.
- Consumes one slow tap of the divided-clock bus. Synchronizes it into the 50 MHz `clock_in` domain and edge-detects it.
- Prescales tap edges to 1 s and counts the loaded period down to 00:00.
- Provides start/pause/load control and drives the display digit outputs and the end-of-period indication.

Parameters:
- TICKS_PER_SEC, default 1000: tap rising edges per game second. Legal range 2..65535. Benches override it to 4.
- PRESC_W, default 16: prescaler width. Must hold TICKS_PER_SEC-1.

Ports:
- clock_in  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous, active-low reset
- tick_in  input  1  divided-clock tap, level signal, asynchronous to usage
- start  input  1  one-cycle pulse: begin or resume the countdown
- pause  input  1  one-cycle pulse: halt the countdown
- load  input  1  one-cycle pulse: load a new period
- load_min  input  8  BCD minutes, 00..99
- load_sec  input  8  BCD seconds, 00..59
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD display digits
- running  output  1  high while in RUN
- sec_pulse  output  1  one-cycle pulse on each game-second decrement
- expired  output  1  one-cycle pulse when the count reaches 00:00
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Clock and reset: one clock, `clock_in`. Reset `reset_n` is asynchronous and active-low.
- Reset values: all digits 0; state IDLE; synchronizer, edge and prescaler registers 0; running, sec_pulse, expired and load_err all 0. Reset asserted mid-count aborts immediately, with no pulse emitted.
- Tick path:
  - tick_in passes through a 2-flop synchronizer, then a previous-value register.
  - tick_edge = sync2 & ~prev.
  - A tap rising edge first sampled at clock edge k produces tick_edge during the cycle after edge k+1.
  - The prescaler acts on tick_edge at edge k+2.
  - Tap falling edges are ignored.
- Prescaler:
  - Increments on tick_edge only in RUN.
  - At TICKS_PER_SEC-1 with tick_edge, it wraps to 0 and decrements the time by one second in the same cycle.
  - Holds its value in PAUSED, so sub-second phase is preserved.
  - Cleared by load and by reset.
- BCD decrement:
  - sec_ones 0 → 9 with borrow.
  - sec_tens 0 → 5 with borrow.
  - min_ones 0 → 9 with borrow.
  - min_tens decrements.
  - Never decrements below 00:00.
- sec_pulse: registered, high for the cycle after each decrement. Also asserted on the final decrement to 00:00.
- States:
  - IDLE:
    - load with valid data → digits loaded, stay IDLE.
    - start with time ≠ 00:00 → RUN.
    - start at 00:00 → ignored.
  - RUN:
    - Decrement reaching 00:00 → EXPIRED; expired pulses in the following cycle.
    - pause → PAUSED.
    - load (valid) → IDLE with new time.
  - PAUSED:
    - start → RUN.
    - load (valid) → IDLE.
    - pause → ignored.
  - EXPIRED:
    - Digits hold 00:00.
    - start → ignored.
    - load (valid) → IDLE.
- Priority for same-cycle controls: load > pause > start.
  - pause and start together in RUN → PAUSED.
  - pause and start together in PAUSED → stay PAUSED.
- Simultaneous pause and final decrement: the decrement is applied; the state goes to EXPIRED, not PAUSED; expired still pulses.
- Simultaneous load and tick wrap: load wins. The decrement is discarded, no sec_pulse, prescaler cleared.
- Load validation:
  - Any BCD nibble > 9, or load_sec tens > 5 → load rejected.
  - On rejection, state and digits are unchanged and load_err pulses in the next cycle.
  - A valid load of 00:00 is accepted: state IDLE, digits 00:00.
- running is a registered decode of RUN. It changes on the same edge as the state.

Test Plan (TICKS_PER_SEC=4; tick_in toggles every 4 clocks, period 8):
- Reset release, then load 01:05, then start → running=1; after 16 tap rising edges (4 s) digits read 01:01 and 4 sec_pulses have been seen.
- Load 00:02, start, wait → sec_pulse twice; expired pulses once; digits 00:00; running=0; further start ignored.
- Load 10:00, run 1 s → digits 09:59, confirming cascaded borrow across all digits.
- RUN with 2 tap edges accumulated, pause for 20 tap edges, then start → the next decrement occurs after exactly 2 more tap edges; digits unchanged during pause.
- load_sec=8'h60 (tens > 5), and separately load_min=8'h1A → load_err pulses each time; prior time and state retained.
- Mid-RUN reset_n low for 1 cycle asynchronously (between clock edges) → all outputs 0, state IDLE; with load and tick wrap in the same cycle → no sec_pulse, new value loaded.

Source files
------------

// File: rtl/game_timer.sv
// Countdown game clock (MM:SS, BCD) driven by a slow divided-clock tap.
// The tap is synchronized and edge-detected, prescaled to game seconds, and counted down to 00:00.
module game_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int PRESC_W       = 16
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       sec_pulse,
  output logic       expired,
  output logic       load_err
);

  // state   | meaning
  // IDLE    | loaded (or reset), waiting for start
  // RUN     | counting down on prescaled tap edges
  // PAUSED  | halted, prescaler phase preserved
  // EXPIRED | reached 00:00, waiting for a load
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sync1, r_sync2, r_prev;
  logic [PRESC_W-1:0]  r_presc;
  logic [3:0]          r_mt, r_mo, r_st, r_so;
  logic [3:0]          w_mt, w_mo, w_st, w_so;
  logic                r_running, r_sec_pulse, r_expired, r_load_err;
  logic                w_tick_edge, w_load_ok, w_load_acc, w_zero, w_dec_zero, w_wrap, w_presc_max;

  assign w_tick_edge = r_sync2 & ~r_prev;
  assign w_load_ok   = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                       (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);
  assign w_load_acc  = load & w_load_ok;
  assign w_zero      = ({r_mt, r_mo, r_st, r_so} == 16'h0000);
  assign w_presc_max = (r_presc == PRESC_W'(TICKS_PER_SEC - 1));
  assign w_wrap      = (r_state == RUN) && w_tick_edge && w_presc_max && !w_zero;
  assign w_dec_zero  = ({w_mt, w_mo, w_st, w_so} == 16'h0000);

  // Cascaded BCD borrow: seconds ones, seconds tens (mod 6), minutes ones, minutes tens.
  always_comb begin
    w_mt = r_mt;
    w_mo = r_mo;
    w_st = r_st;
    w_so = r_so;
    if (r_so != 4'd0) begin
      w_so = r_so - 4'd1;
    end else begin
      w_so = 4'd9;
      if (r_st != 4'd0) begin
        w_st = r_st - 4'd1;
      end else begin
        w_st = 4'd5;
        if (r_mo != 4'd0) begin
          w_mo = r_mo - 4'd1;
        end else begin
          w_mo = 4'd9;
          w_mt = r_mt - 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      if (w_load_ok) w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start && !w_zero) w_state_nxt = RUN;
        RUN: begin
          if (w_wrap && w_dec_zero) w_state_nxt = EXPIRED;
          else if (pause)           w_state_nxt = PAUSED;
        end
        PAUSED:  if (start && !pause) w_state_nxt = RUN;
        EXPIRED: w_state_nxt = EXPIRED;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_presc     <= '0;
      r_mt        <= 4'd0;
      r_mo        <= 4'd0;
      r_st        <= 4'd0;
      r_so        <= 4'd0;
      r_running   <= 1'b0;
      r_sec_pulse <= 1'b0;
      r_expired   <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_sync1     <= tick_in;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_running   <= (w_state_nxt == RUN);
      r_sec_pulse <= w_wrap & ~load;
      r_expired   <= w_wrap & w_dec_zero & ~load;
      r_load_err  <= load & ~w_load_ok;
      // A rejected load freezes everything for that cycle; an accepted one wins over a wrap.
      if (w_load_acc) begin
        r_presc <= '0;
        r_mt    <= load_min[7:4];
        r_mo    <= load_min[3:0];
        r_st    <= load_sec[7:4];
        r_so    <= load_sec[3:0];
      end else if (!load) begin
        if (r_state == RUN && w_tick_edge) begin
          r_presc <= w_presc_max ? '0 : r_presc + 1'b1;
        end
        if (w_wrap) begin
          r_mt <= w_mt;
          r_mo <= w_mo;
          r_st <= w_st;
          r_so <= w_so;
        end
      end
    end
  end

  assign min_tens  = r_mt;
  assign min_ones  = r_mo;
  assign sec_tens  = r_st;
  assign sec_ones  = r_so;
  assign running   = r_running;
  assign sec_pulse = r_sec_pulse;
  assign expired   = r_expired;
  assign load_err  = r_load_err;

endmodule
